// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (instruction fetch / data) arbiter in front of a
// single-ported synchronous memory with a fixed read latency.
//
// Ports:
//   clk, reset          single clock, asynchronous active-low reset
//   i_req/i_addr        fetch request (held until i_ack)
//   i_ack/i_rdata       fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ack)
//   d_ack/d_rdata       data completion pulse and read word
//   m_en/m_we/m_addr/m_wdata/m_rdata  memory side
//   grant               current owner: 00 none, 01 instruction, 10 data
//   stall_fetch         i_req and not i_ack, used to freeze fetch
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; a request present at the edge is granted
// ISSUE | one-cycle memory strobe for the registered owner
// WAIT  | LAT cycles of memory latency; read data captured on the last
// RESP  | one-cycle ack to the owner, then back to IDLE
module mem_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int LAT    = 1,
    parameter int STARVE = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [1:0]    grant,
    output logic          stall_fetch
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] STARVE_C  = 3'(STARVE);
    localparam logic [1:0] WAIT_INIT = 2'(LAT - 1);

    state_t        state_q, state_d;
    logic          own_data_q, own_data_d;   // 1 = data owns the memory
    logic          we_q, we_d;
    logic [2:0]    starve_q, starve_d;
    logic [1:0]    wait_q, wait_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          win_data;

    // Data normally wins; once it has been granted STARVE times in a row
    // while a fetch waits, the fetch gets the next slot.
    assign win_data = d_req && (!i_req || (starve_q != STARVE_C));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            starve_q   <= 3'd0;
            wait_q     <= 2'd0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            own_data_q <= own_data_d;
            we_q       <= we_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_req || d_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_q == 2'd0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered datapath: grant capture, starve counter, latency timer,
    // read-data capture.
    always_comb begin
        own_data_d = own_data_q;
        we_d       = we_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    own_data_d = win_data;
                    we_d       = win_data && d_we;
                    m_addr_d   = win_data ? d_addr : i_addr;
                    if (win_data) begin
                        m_wdata_d = d_wdata;
                        if (i_req && (starve_q != STARVE_C)) begin
                            starve_d = starve_q + 3'd1;
                        end
                    end else begin
                        starve_d = 3'd0;
                    end
                end
            end
            S_ISSUE: wait_d = WAIT_INIT;
            S_WAIT: begin
                if (wait_q != 2'd0) begin
                    wait_d = wait_q - 2'd1;
                end else if (!own_data_q) begin
                    i_rdata_d = m_rdata;
                end else if (!we_q) begin
                    d_rdata_d = m_rdata;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        grant = 2'b00;
        m_en  = 1'b0;
        m_we  = 1'b0;
        i_ack = 1'b0;
        d_ack = 1'b0;
        if (state_q != S_IDLE) begin
            grant = own_data_q ? 2'b10 : 2'b01;
        end
        if (state_q == S_ISSUE) begin
            m_en = 1'b1;
            m_we = own_data_q && we_q;
        end
        if (state_q == S_RESP) begin
            i_ack = !own_data_q;
            d_ack = own_data_q;
        end
    end

    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign stall_fetch = i_req && !i_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed
// scenarios. A second instance with LAT=3 checks the longer latency.
module tb_mem_arbiter;

    localparam int LAT    = 1;
    localparam int STARVE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [9:0]  i_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0, m_rdata = '0;
    logic        i_ack, d_ack, m_en, m_we, stall_fetch;
    logic [31:0] i_rdata, d_rdata, m_wdata;
    logic [9:0]  m_addr;
    logic [1:0]  grant;

    // LAT=3 instance
    logic        i_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
    logic [9:0]  i_addr3 = '0, d_addr3 = '0;
    logic [31:0] d_wdata3 = '0, m_rdata3 = '0;
    logic        i_ack3, d_ack3, m_en3, m_we3, stall_fetch3;
    logic [31:0] i_rdata3, d_rdata3, m_wdata3;
    logic [9:0]  m_addr3;
    logic [1:0]  grant3;

    mem_arbiter #(.AW(10), .DW(32), .LAT(LAT), .STARVE(STARVE)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .grant(grant), .stall_fetch(stall_fetch)
    );

    mem_arbiter #(.AW(10), .DW(32), .LAT(3), .STARVE(STARVE)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
        .m_rdata(m_rdata3), .grant(grant3), .stall_fetch(stall_fetch3)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: reads answer in the cycle LAT after the strobe, junk otherwise.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_sched [int];

    always @(negedge clk) begin
        m_rdata  = rd_sched.exists(cyc) ? rd_sched[cyc] : (32'hBAD0_0000 ^ 32'(cyc));
        m_rdata3 = 32'hA500_0000 | 32'(cyc);
        if (m_en) begin
            if (m_we) mem[m_addr] = m_wdata;
            else      rd_sched[cyc + LAT] = mem[m_addr];
        end
    end

    // Reference model: one transaction at a time, ISSUE in cycle t0,
    // ack in cycle t0+LAT+1, next grant possible at the end of t0+LAT+2.
    bit          busy = 1'b0;
    int          t0 = 0;
    logic [1:0]  own = 2'b00;
    bit          own_we = 1'b0;
    int          starve = 0;
    logic [31:0] word = '0;
    logic [31:0] e_i_rdata = '0, e_d_rdata = '0, e_m_wdata = '0;
    logic [9:0]  e_m_addr = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy = 1'b0; starve = 0;
            e_i_rdata = '0; e_d_rdata = '0; e_m_addr = '0; e_m_wdata = '0;
        end else if (busy) begin
            if (cyc == t0 + LAT) begin
                if (own == 2'b01) e_i_rdata = word;
                else if (!own_we) e_d_rdata = word;
            end
            if (cyc == t0 + LAT + 1) busy = 1'b0;
        end else if (i_req || d_req) begin
            bit pick_d;
            pick_d = d_req && !(i_req && starve == STARVE);
            busy = 1'b1;
            t0 = cyc + 1;
            own = pick_d ? 2'b10 : 2'b01;
            own_we = pick_d && d_we;
            e_m_addr = pick_d ? d_addr : i_addr;
            if (pick_d) e_m_wdata = d_wdata;
            word = mem[e_m_addr];
            if (pick_d) begin
                if (i_req && starve < STARVE) starve++;
            end else begin
                starve = 0;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            int  k;
            bit  e_men, e_iack, e_dack;
            k      = cyc - t0;
            e_men  = busy && k == 0;
            e_iack = busy && k == LAT + 1 && own == 2'b01;
            e_dack = busy && k == LAT + 1 && own == 2'b10;
            check("grant",   64'(grant),   busy ? 64'(own) : 64'd0);
            check("m_en",    64'(m_en),    64'(e_men));
            check("m_we",    64'(m_we),    64'(e_men && own_we));
            check("i_ack",   64'(i_ack),   64'(e_iack));
            check("d_ack",   64'(d_ack),   64'(e_dack));
            check("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
            check("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
            check("m_addr",  64'(m_addr),  64'(e_m_addr));
            check("m_wdata", 64'(m_wdata), 64'(e_m_wdata));
            check("stall",   64'(stall_fetch), 64'(i_req && !e_iack));
        end
    end

    // Requester helper: counts acks/strobes and drops a request on its ack.
    logic [1:0]  grants[$];
    int          i_acks, d_acks;
    logic        last_we;
    logic [9:0]  last_addr;
    logic [31:0] last_wdata;

    task automatic clear_log();
        grants.delete();
        i_acks = 0;
        d_acks = 0;
    endtask

    task automatic run(input int n, input bit keep_d);
        repeat (n) begin
            @(negedge clk);
            if (m_en) begin
                grants.push_back(grant);
                last_we = m_we; last_addr = m_addr; last_wdata = m_wdata;
            end
            if (i_ack) i_acks++;
            if (d_ack) d_acks++;
            #1;
            if (i_ack) i_req = 1'b0;
            if (d_ack && !keep_d) d_req = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
        mem[4] = 32'h2008_0005;

        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_m_en",  64'(m_en),  64'd0);
        check("rst_i_ack", 64'(i_ack), 64'd0);
        check("rst_d_ack", 64'(d_ack), 64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;

        // Single fetch, LAT=1
        @(negedge clk); #1;
        i_req = 1'b1; i_addr = 10'h004;
        #1 check("t1_stall_c0", 64'(stall_fetch), 64'd1);
        @(negedge clk);
        check("t1_m_en_c1", 64'(m_en), 64'd1);
        check("t1_m_addr_c1", 64'(m_addr), 64'h004);
        check("t1_grant_c1", 64'(grant), 64'd1);
        @(negedge clk);
        check("t1_stall_c2", 64'(stall_fetch), 64'd1);
        check("t1_m_en_c2", 64'(m_en), 64'd0);
        @(negedge clk);
        check("t1_i_ack_c3", 64'(i_ack), 64'd1);
        check("t1_i_rdata_c3", 64'(i_rdata), 64'h2008_0005);
        check("t1_stall_c3", 64'(stall_fetch), 64'd0);
        #1 i_req = 1'b0;
        run(2, 1'b0);

        // Simultaneous requests: data first, then fetch
        clear_log();
        i_req = 1'b1; i_addr = 10'h008;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
        run(12, 1'b0);
        check("t2_n_grants", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("t2_first", 64'(grants[0]), 64'd2);
            check("t2_second", 64'(grants[1]), 64'd1);
        end
        check("t2_acks", 64'({i_acks[7:0], d_acks[7:0]}), 64'h0101);
        check("t2_d_rdata", 64'(d_rdata), 64'hC0DE_0020);
        check("t2_i_rdata", 64'(i_rdata), 64'hC0DE_0008);
        check("t2_model_starve", 64'(starve), 64'd0);

        // Starvation limit: data held continuously, fetch waiting
        clear_log();
        i_req = 1'b1; i_addr = 10'h00C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h024;
        run(14, 1'b1);
        d_req = 1'b0;
        run(6, 1'b0);
        check("t3_n_grants", 64'(grants.size()), 64'd4);
        if (grants.size() == 4) begin
            check("t3_g0", 64'(grants[0]), 64'd2);
            check("t3_g1", 64'(grants[1]), 64'd2);
            check("t3_g2", 64'(grants[2]), 64'd1);
            check("t3_g3", 64'(grants[3]), 64'd2);
        end
        check("t3_acks", 64'({i_acks[7:0], d_acks[7:0]}), 64'h0103);

        // Write; requester fields change after grant and must be ignored
        clear_log();
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h010; d_wdata = 32'hDEAD_BEEF;
        run(1, 1'b0);
        d_we = 1'b0; d_addr = 10'h3FF; d_wdata = 32'h0;
        run(5, 1'b0);
        check("t4_n_men", 64'(grants.size()), 64'd1);
        check("t4_m_we", 64'(last_we), 64'd1);
        check("t4_m_addr", 64'(last_addr), 64'h010);
        check("t4_m_wdata", 64'(last_wdata), 64'hDEAD_BEEF);
        check("t4_d_acks", 64'(d_acks), 64'd1);
        check("t4_d_rdata_kept", 64'(d_rdata), 64'hC0DE_0024);

        // Read back the written word
        clear_log();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        run(1, 1'b0);
        d_addr = 10'h055;
        run(5, 1'b0);
        check("t5_d_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
        check("t5_m_we", 64'(last_we), 64'd0);

        // A data request dropped before it is granted is lost
        clear_log();
        i_req = 1'b1; i_addr = 10'h004;
        run(1, 1'b0);
        d_req = 1'b1; d_addr = 10'h020;
        run(1, 1'b0);
        d_req = 1'b0;
        run(6, 1'b0);
        check("t6_lost_d_acks", 64'(d_acks), 64'd0);
        check("t6_i_acks", 64'(i_acks), 64'd1);

        // Reset during WAIT
        clear_log();
        i_req = 1'b1; i_addr = 10'h030;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t7_grant", 64'(grant), 64'd0);
        check("t7_m_en", 64'(m_en), 64'd0);
        check("t7_m_we", 64'(m_we), 64'd0);
        check("t7_acks", 64'({i_ack, d_ack}), 64'd0);
        check("t7_i_rdata", 64'(i_rdata), 64'd0);
        check("t7_d_rdata", 64'(d_rdata), 64'd0);
        check("t7_m_addr", 64'(m_addr), 64'd0);
        check("t7_m_wdata", 64'(m_wdata), 64'd0);
        i_req = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        run(6, 1'b0);
        check("t7_no_ack", 64'(i_acks), 64'd0);
        i_req = 1'b1; i_addr = 10'h004;
        run(6, 1'b0);
        check("t7_new_acks", 64'(i_acks), 64'd1);
        check("t7_new_rdata", 64'(i_rdata), 64'h2008_0005);

        // LAT=3 instance: data read
        begin
            int g, ack_at, n_men3, n_ack3;
            logic [31:0] rd3;
            ack_at = -1; n_men3 = 0; n_ack3 = 0; rd3 = '0;
            @(negedge clk); #1;
            d_req3 = 1'b1; d_addr3 = 10'h007; g = cyc;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (m_en3) n_men3++;
                if (d_ack3) begin
                    n_ack3++;
                    ack_at = cyc - g;
                    rd3 = d_rdata3;
                    #1 d_req3 = 1'b0;
                end
            end
            check("t8_ack_cycle", 64'(ack_at), 64'd5);
            check("t8_n_m_en", 64'(n_men3), 64'd1);
            check("t8_n_ack", 64'(n_ack3), 64'd1);
            check("t8_d_rdata", 64'(rd3), 64'(32'hA500_0000 | 32'(g + 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning word address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter LAT, default 1, meaning memory read latency in cycles; legal range is 1..4.
REQ-004 The block SHALL have parameter STARVE, default 2, meaning the maximum consecutive data grants while an instruction request waits; legal range is 1..7.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 i_req  in  1  instruction fetch request, held until i_ack.
REQ-008 i_addr  in  AW  fetch address.
REQ-009 i_ack  out  1  one-cycle fetch completion pulse.
REQ-010 i_rdata  out  DW  fetched word, valid from the i_ack cycle and held until the next instruction completion.
REQ-011 d_req  in  1  data request, held until d_ack.
REQ-012 d_we  in  1  data write enable; 1 = write, 0 = read.
REQ-013 d_addr  in  AW  data address.
REQ-014 d_wdata  in  DW  write data.
REQ-015 d_ack  out  1  one-cycle data completion pulse.
REQ-016 d_rdata  out  DW  read word, valid from the d_ack cycle and held otherwise.
REQ-017 m_en  out  1  memory access strobe.
REQ-018 m_we  out  1  memory write strobe.
REQ-019 m_addr  out  AW  memory address.
REQ-020 m_wdata  out  DW  memory write data.
REQ-021 m_rdata  in  DW  memory read data, valid LAT cycles after the m_en cycle.
REQ-022 grant  out  2  current owner: 00 none, 01 instruction, 10 data.
REQ-023 stall_fetch  out  1  combinational i_req AND NOT i_ack, used to freeze fetch.

Function
REQ-024 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-025 IDLE: on a rising edge with any request high, the block SHALL select a winner, register the address, the write enable and (for data) the write data, and enter ISSUE; with no request it SHALL stay in IDLE.
REQ-026 Arbitration: data SHALL win a simultaneous request unless the starve counter equals STARVE, in which case instruction SHALL win.
REQ-027 Starve counter: it SHALL increment, saturating at STARVE, on each data grant made while i_req is high; it SHALL clear on any instruction grant.
REQ-028 ISSUE: the block SHALL drive m_en=1 for exactly one cycle.
REQ-029 ISSUE: m_we SHALL be 1 only when the owner is data and the registered d_we is 1.
REQ-030 ISSUE: the block SHALL then enter WAIT.
REQ-031 WAIT: the block SHALL stay for LAT cycles, counted down to zero, and SHALL capture m_rdata on the final WAIT edge.
REQ-032 RESP: the block SHALL assert the owner's ack for exactly one cycle.
REQ-033 RESP: on a read, the captured word SHALL appear on the owner's rdata in that cycle.
REQ-034 RESP: the block SHALL then return to IDLE.
REQ-035 Latency: the ack SHALL occur LAT+2 cycles after the edge at which the request was granted; the instruction port SHALL never write.
REQ-036 Requester address, data and d_we changes after the grant SHALL be ignored until the next grant.
REQ-037 A request still high in the IDLE cycle after its ack SHALL be treated as a new transaction; there SHALL be no duplicate ack for the completed one.
REQ-038 On a data write, d_rdata SHALL remain unchanged.
REQ-039 m_addr and m_wdata SHALL hold their last values outside ISSUE.
REQ-040 grant SHALL be nonzero from ISSUE through RESP and 00 in IDLE.
REQ-041 A request that drops before it is granted SHALL be lost silently and SHALL produce no ack.

Reset
REQ-042 reset low SHALL asynchronously force IDLE and set m_en, m_we, i_ack, d_ack and grant to 0.
REQ-043 reset low SHALL asynchronously clear the starve counter and the WAIT counter.
REQ-044 reset low SHALL asynchronously set i_rdata, d_rdata, m_addr and m_wdata to 0.
REQ-045 An in-flight transaction cut by reset SHALL be discarded and SHALL never be acked.
REQ-046 The first grant after release SHALL occur on the first rising edge with reset high and a request present.

Verification
REQ-047 LAT=1, i_req with i_addr=0x004, memory returns 0x20080005 -> m_en high with m_addr=0x004 one cycle after grant; i_ack high on cycle 3 with i_rdata=0x20080005; stall_fetch high cycles 0-2.
REQ-048 i_req and d_req rise on the same edge -> grant=10 first, d_ack, then grant=01, i_ack; counter then 0.
REQ-049 STARVE=2, d_req held continuously and i_req held -> data, data, then instruction granted third; the data request waits.
REQ-050 Write with d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> one cycle of m_en=m_we=1 with m_addr=0x10 and m_wdata=0xDEADBEEF, d_ack pulse, d_rdata unchanged.
REQ-051 reset driven low during WAIT -> all outputs 0 immediately without a clock edge; no ack after release; a new i_req completes normally.
REQ-052 LAT=3, d read -> d_ack on cycle 5 after grant; m_en asserted exactly once.
